// File: rtl/chan_packet_pkg.sv
// Shared types and register field layout for the channelizer bin packet capture path.
package chan_packet_pkg;

   localparam int unsigned EN_BIT    = 31;
   localparam int unsigned FIRST_LSB = 16;
   localparam int unsigned NUM_LSB   = 0;
   localparam int unsigned CNT_W     = 16;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StWait    = 2'd1,
      StCapture = 2'd2
   } cap_state_e;

endpackage

// File: rtl/chan_packet_commit_fifo.sv
// Commit/rewind FIFO: writes stay invisible to the reader until committed; a rewind
// discards everything written since the last commit.
module chan_packet_commit_fifo #(
   parameter int unsigned DW      = 32,
   parameter int unsigned FIFO_AW = 9
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr,
   input  logic [DW:0]        wr_word,
   input  logic               commit,
   input  logic               rewind,
   output logic [FIFO_AW+1:0] free,
   output logic [DW-1:0]      out_data,
   output logic               out_last,
   output logic               out_valid,
   input  logic               out_ready
);

   localparam int unsigned PW = FIFO_AW + 1;

   logic [DW:0]   mem [2**FIFO_AW];
   logic [PW-1:0] wr_ptr_q, cm_ptr_q, cm_vis_q, rd_ptr_q;
   logic [PW-1:0] waddr, used;
   logic          avail, load;

   // A rewind in the same cycle as a write places the word at the commit point.
   assign waddr = rewind ? cm_ptr_q : wr_ptr_q;
   assign used  = cm_ptr_q - rd_ptr_q;
   assign free  = (PW + 1)'(2**FIFO_AW) - {1'b0, used};
   assign avail = cm_vis_q != rd_ptr_q;
   assign load  = avail && (!out_valid || out_ready);

   always_ff @(posedge clk) begin
      if (wr) begin
         mem[waddr[FIFO_AW-1:0]] <= wr_word;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         cm_ptr_q <= '0;
         cm_vis_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr) begin
            wr_ptr_q <= waddr + PW'(1);
         end else if (rewind) begin
            wr_ptr_q <= cm_ptr_q;
         end
         if (commit) begin
            cm_ptr_q <= waddr + PW'(1);
         end
         // Read side sees the commit point one cycle late, giving BRAM write-to-read margin.
         cm_vis_q <= cm_ptr_q;
         if (load) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         {out_last, out_data} <= mem[rd_ptr_q[FIFO_AW-1:0]];
         out_valid            <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/chan_packet_bin_capture.sv
// Captures a configurable window of bins from each spectrum frame and releases it as an
// all-or-nothing packet; frames that cannot fit are dropped, interrupted ones rewound.
module chan_packet_bin_capture
   import chan_packet_pkg::*;
#(
   parameter int unsigned DW      = 32,
   parameter int unsigned NBINS   = 256,
   parameter int unsigned FIFO_AW = 9
) (
   input  logic             user_clk,
   input  logic             user_rst_n,
   input  logic [31:0]      bins_reg,
   input  logic [DW-1:0]    din,
   input  logic             din_valid,
   input  logic             din_sync,
   output logic [DW-1:0]    out_data,
   output logic             out_valid,
   output logic             out_last,
   input  logic             out_ready,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] drop_cnt,
   output logic [CNT_W-1:0] abort_cnt
);

   localparam int unsigned BIN_W = $clog2(NBINS);

   cap_state_e         state_q, state_d;
   logic               sync;
   logic [BIN_W-1:0]   bin_cnt_q, bin_idx;
   logic               new_en;
   logic [BIN_W-1:0]   new_first, new_last;
   logic [BIN_W:0]     new_num, span, new_len;
   logic [BIN_W-1:0]   first_q, last_q;
   logic [FIFO_AW+1:0] free;
   logic               start_ok, fits;
   logic               wr, wr_last, commit, rewind;
   logic               inc_frame, inc_drop, inc_abort;
   logic               unused_bits;

   assign unused_bits = ^{bins_reg[EN_BIT-1:FIRST_LSB+BIN_W],
                          bins_reg[FIRST_LSB-1:NUM_LSB+BIN_W+1]};

   assign sync    = din_valid & din_sync;
   assign bin_idx = sync ? '0 : bin_cnt_q;

   // Window is clipped at the top of the frame.
   assign new_en    = bins_reg[EN_BIT];
   assign new_first = bins_reg[FIRST_LSB +: BIN_W];
   assign new_num   = bins_reg[NUM_LSB +: BIN_W+1];
   assign span      = (BIN_W + 1)'(NBINS) - {1'b0, new_first};
   assign new_len   = (new_num > span) ? span : new_num;
   assign new_last  = BIN_W'({1'b0, new_first} + new_len - (BIN_W + 1)'(1));
   assign start_ok  = new_en && (new_len != '0);
   assign fits      = 32'(free) >= 32'(new_len);

   always_ff @(posedge user_clk) begin
      if (!user_rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (sync) begin
         if (start_ok && fits) begin
            if (new_first != '0) begin
               state_d = StWait;
            end else begin
               state_d = (new_last == '0) ? StIdle : StCapture;
            end
         end else begin
            state_d = StIdle;
         end
      end else if (din_valid) begin
         case (state_q)
            StWait: begin
               if (bin_idx == first_q) begin
                  state_d = (bin_idx == last_q) ? StIdle : StCapture;
               end
            end
            StCapture: begin
               if (bin_idx == last_q) begin
                  state_d = StIdle;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      wr        = 1'b0;
      wr_last   = 1'b0;
      rewind    = 1'b0;
      inc_frame = 1'b0;
      inc_drop  = 1'b0;
      inc_abort = 1'b0;
      if (sync) begin
         inc_frame = 1'b1;
         if (state_q != StIdle) begin
            rewind    = 1'b1;
            inc_abort = 1'b1;
         end
         if (start_ok && !fits) begin
            inc_drop = 1'b1;
         end
         if (start_ok && fits && (new_first == '0)) begin
            wr      = 1'b1;
            wr_last = (new_last == '0);
         end
      end else if (din_valid) begin
         if ((state_q == StWait && bin_idx == first_q) || state_q == StCapture) begin
            wr      = 1'b1;
            wr_last = (bin_idx == last_q);
         end
      end
      commit = wr & wr_last;
   end

   always_ff @(posedge user_clk) begin
      if (!user_rst_n) begin
         bin_cnt_q <= '0;
         first_q   <= '0;
         last_q    <= '0;
         frame_cnt <= '0;
         drop_cnt  <= '0;
         abort_cnt <= '0;
      end else begin
         if (din_valid) begin
            bin_cnt_q <= bin_idx + BIN_W'(1);
         end
         if (sync) begin
            first_q <= new_first;
            last_q  <= new_last;
         end
         if (inc_frame) frame_cnt <= frame_cnt + CNT_W'(1);
         if (inc_drop)  drop_cnt  <= drop_cnt + CNT_W'(1);
         if (inc_abort) abort_cnt <= abort_cnt + CNT_W'(1);
      end
   end

   chan_packet_commit_fifo #(
      .DW      (DW),
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk       (user_clk),
      .rst_n     (user_rst_n),
      .wr        (wr),
      .wr_word   ({wr_last, din}),
      .commit    (commit),
      .rewind    (rewind),
      .free      (free),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

endmodule

// File: tb/tb_chan_packet_bin_capture.sv
// Scoreboard bench for chan_packet_bin_capture: directed frames push expected packet words,
// a negedge monitor pops and compares on every transfer.
module tb_chan_packet_bin_capture;

   localparam int unsigned DW      = 32;
   localparam int unsigned NBINS   = 256;
   localparam int unsigned FIFO_AW = 4;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic [31:0]   bins_reg  = '0;
   logic [DW-1:0] din       = '0;
   logic          din_valid = 1'b0;
   logic          din_sync  = 1'b0;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic          out_valid, out_last;
   logic [15:0]   frame_cnt, drop_cnt, abort_cnt;

   int checks = 0;
   int errors = 0;
   logic [DW:0] sb[$];

   always #5 clk = ~clk;

   chan_packet_bin_capture #(
      .DW      (DW),
      .NBINS   (NBINS),
      .FIFO_AW (FIFO_AW)
   ) dut (
      .user_clk   (clk),
      .user_rst_n (rst_n),
      .bins_reg   (bins_reg),
      .din        (din),
      .din_valid  (din_valid),
      .din_sync   (din_sync),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .frame_cnt  (frame_cnt),
      .drop_cnt   (drop_cnt),
      .abort_cnt  (abort_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Packet word = {last, frame id, bin index}.
   task automatic expect_pkt(input int fid, input int first, input int len);
      for (int b = first; b < first + len; b++) begin
         sb.push_back({(b == first + len - 1), 16'(fid), 16'(b)});
      end
   endtask

   task automatic send_frame(input int fid, input logic [31:0] reg_val, input int nbins,
                             input int chg_at, input logic [31:0] chg_val, input bit gaps);
      bins_reg = reg_val;
      for (int b = 0; b < nbins; b++) begin
         if (gaps && (b % 5 == 2)) begin
            din_valid = 1'b0;
            din_sync  = 1'b0;
            @(posedge clk); #1;
         end
         if (b == chg_at) bins_reg = chg_val;
         din_valid = 1'b1;
         din_sync  = (b == 0);
         din       = {16'(fid), 16'(b)};
         @(posedge clk); #1;
      end
      din_valid = 1'b0;
      din_sync  = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, 64'(sb.size()), 64'd0);
   endtask

   initial begin : monitor
      logic [DW:0] held;
      logic [DW:0] exp;
      bit          hold_pend;
      hold_pend = 1'b0;
      held      = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_pend = 1'b0;
         end else begin
            if (hold_pend) begin
               chk("hold_stable", {out_valid, out_last, out_data}, {1'b1, held});
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word: got %h, want no word", {out_last, out_data});
               end else begin
                  exp = sb.pop_front();
                  chk("pkt_word", {out_last, out_data}, exp);
               end
            end
            hold_pend = out_valid && !out_ready;
            held      = {out_last, out_data};
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   initial begin : stim
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_abort_cnt", abort_cnt, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic window with idle gaps in the bin stream.
      expect_pkt(1, 4, 3);
      send_frame(1, 32'h8004_0003, 256, -1, '0, 1'b1);
      chk("t1_frame_cnt", frame_cnt, 1);

      // first=250,num=10 clips to bins 250..255.
      expect_pkt(2, 250, 6);
      send_frame(2, 32'h80FA_000A, 256, -1, '0, 1'b0);
      wait_drain("t2_drain");
      chk("t2_frame_cnt", frame_cnt, 2);

      // Back-pressure: second 10-word frame cannot fit in a 16-entry FIFO.
      out_ready = 1'b0;
      expect_pkt(3, 0, 10);
      send_frame(3, 32'h8000_000A, 256, -1, '0, 1'b0);
      send_frame(4, 32'h8000_000A, 256, -1, '0, 1'b0);
      chk("t3_drop_cnt", drop_cnt, 1);
      chk("t3_frame_cnt", frame_cnt, 4);
      chk("t3_head_word", {out_valid, out_last, out_data}, {2'b10, 32'h0003_0000});
      out_ready = 1'b1;
      wait_drain("t3_drain");

      // Early sync at bin 5 aborts window 2..9; next frame starts at bin 0.
      expect_pkt(6, 0, 4);
      send_frame(5, 32'h8002_0008, 5, -1, '0, 1'b0);
      send_frame(6, 32'h8000_0004, 256, -1, '0, 1'b0);
      wait_drain("t4_drain");
      chk("t4_abort_cnt", abort_cnt, 1);
      chk("t4_frame_cnt", frame_cnt, 6);

      // Mid-frame register change applies only from the next sync.
      expect_pkt(7, 10, 4);
      expect_pkt(8, 20, 2);
      send_frame(7, 32'h800A_0004, 256, 3, 32'h8014_0002, 1'b0);
      send_frame(8, 32'h8014_0002, 256, -1, '0, 1'b0);
      wait_drain("t5_drain");
      chk("t5_frame_cnt", frame_cnt, 8);

      // Disabled and zero-length frames are counted but produce nothing.
      send_frame(9, 32'h0004_0003, 32, -1, '0, 1'b0);
      send_frame(10, 32'h8000_0000, 32, -1, '0, 1'b0);
      wait_drain("t5b_drain");
      chk("t5b_frame_cnt", frame_cnt, 10);
      chk("t5b_drop_cnt", drop_cnt, 1);
      chk("t5b_abort_cnt", abort_cnt, 1);

      // Reset during capture with a committed packet still pending.
      out_ready = 1'b0;
      send_frame(11, 32'h8000_0002, 16, -1, '0, 1'b0);
      send_frame(12, 32'h8000_0008, 4, -1, '0, 1'b0);
      chk("t6_pending_valid", out_valid, 1);
      rst_n = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      chk("t6_rst_out_valid", out_valid, 0);
      chk("t6_rst_frame_cnt", frame_cnt, 0);
      chk("t6_rst_drop_cnt", drop_cnt, 0);
      chk("t6_rst_abort_cnt", abort_cnt, 0);
      @(posedge clk); #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("t6_no_stale", out_valid, 0);

      // Single-bin window at bin 0 commits on the sync cycle itself.
      expect_pkt(13, 0, 1);
      send_frame(13, 32'h8000_0001, 16, -1, '0, 1'b0);
      wait_drain("t6_drain");
      chk("t6_frame_cnt", frame_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
